// File: rtl/reduce_1s.sv
// Serial run-length reducer: reports the length of each
// completed run of 1s on a bit stream, saturating at 7.
module reduce_1s (
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  output logic [2:0] out
);

  typedef enum logic [3:0] {
    S0 = 4'd0,
    S1 = 4'd1,
    S2 = 4'd2,
    S3 = 4'd3,
    S4 = 4'd4,
    S5 = 4'd5,
    S6 = 4'd6,
    S7 = 4'd7
  } state_t;

  state_t state;

  // Run-length FSM; out updates only when a run is closed by a 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S0;
      out   <= 3'd0;
    end else begin
      case (state)
        S0: begin
          if (in) state <= S1;
          else    state <= S0;
        end
        S1, S2, S3, S4, S5, S6: begin
          if (in) begin
            state <= state_t'(state + 4'd1);
          end else begin
            out   <= state[2:0];
            state <= S0;
          end
        end
        S7: begin
          if (!in) begin
            out   <= 3'd7;
            state <= S0;
          end
        end
        default: state <= S0;
      endcase
    end
  end

endmodule

// File: tb/tb_reduce_1s.sv
// Bench for reduce_1s: directed vectors feed a scoreboard
// queue; a monitor checks out after every clock edge.
module tb_reduce_1s;

  logic       clk;
  logic       reset;
  logic       in;
  logic [2:0] out;

  int n_checks;
  int n_fails;

  logic [2:0] exp_q[$];
  string      tag_q[$];

  reduce_1s dut (
    .clk  (clk),
    .reset(reset),
    .in   (in),
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive n cycles of (rst, b); after each edge, out must equal e.
  task automatic drive(input logic r, input logic b,
                       input int n, input logic [2:0] e,
                       input string tag);
    for (int i = 0; i < n; i++) begin
      reset = r;
      in    = b;
      @(posedge clk);
      exp_q.push_back(e);
      tag_q.push_back(tag);
      #1;
    end
  endtask

  // Monitor: compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [2:0] e;
      string      t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_checks++;
      if (out !== e) begin
        n_fails++;
        $display("FAIL %s: out=%0d expected=%0d at %0t",
                 t, out, e, $time);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset    = 1'b0;
    in       = 1'b0;
    #1;

    drive(1'b0, 1'b1, 1, 3'd0, "reset_in1");
    drive(1'b0, 1'b0, 1, 3'd0, "reset_in0");
    drive(1'b1, 1'b0, 3, 3'd0, "post_reset_zeros");

    drive(1'b1, 1'b1, 5, 3'd0, "run5_open");
    drive(1'b1, 1'b0, 1, 3'd5, "run5_report");
    drive(1'b1, 1'b0, 2, 3'd5, "run5_hold");

    drive(1'b1, 1'b1, 9, 3'd5, "run9_open");
    drive(1'b1, 1'b0, 1, 3'd7, "run9_sat");
    drive(1'b1, 1'b0, 1, 3'd7, "run9_hold");

    drive(1'b1, 1'b1, 1, 3'd7, "alt_1a");
    drive(1'b1, 1'b0, 1, 3'd1, "alt_0a");
    drive(1'b1, 1'b1, 1, 3'd1, "alt_1b");
    drive(1'b1, 1'b0, 1, 3'd1, "alt_0b");
    drive(1'b1, 1'b1, 1, 3'd1, "alt_1c");
    drive(1'b1, 1'b0, 1, 3'd1, "alt_0c");

    drive(1'b1, 1'b1, 4, 3'd1, "mid_run_open");
    drive(1'b0, 1'b1, 1, 3'd0, "mid_run_reset");
    drive(1'b1, 1'b1, 2, 3'd0, "mid_run_restart");
    drive(1'b1, 1'b0, 1, 3'd2, "mid_run_report");

    drive(1'b1, 1'b1, 7, 3'd2, "run7_open");
    drive(1'b1, 1'b0, 1, 3'd7, "run7_report");
    drive(1'b1, 1'b1, 6, 3'd7, "run6_open");
    drive(1'b1, 1'b0, 1, 3'd6, "run6_report");
    drive(1'b1, 1'b1, 7, 3'd6, "run7b_open");
    drive(1'b1, 1'b0, 1, 3'd7, "run7b_report");
    drive(1'b1, 1'b1, 1, 3'd7, "run1_open");
    drive(1'b1, 1'b0, 1, 3'd1, "run1_report");
    drive(1'b1, 1'b1, 3, 3'd1, "open_run_unreported");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(posedge clk);
    if (exp_q.size() > 0) begin
      n_fails++;
      $display("FAIL drain: pending=%0d expected=0",
               exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
